// File: rtl/rom_access_ctrl_if.sv
// Requester and EPROM pin bundle for rom_access_ctrl.
// slave = controller side, master = requesters plus EPROM model side.
interface rom_access_ctrl_if #(
    parameter int ADDR_W = 15
);
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              ack0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              ack1;
    logic [7:0]        rdata;
    logic              busy;
    logic              rom_csN;
    logic              rom_oeN;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;

    modport slave (
        input  req0, addr0, req1, addr1, rom_data,
        output ack0, ack1, rdata, busy, rom_csN, rom_oeN, rom_addr
    );

    modport master (
        output req0, addr0, req1, addr1, rom_data,
        input  ack0, ack1, rdata, busy, rom_csN, rom_oeN, rom_addr
    );
endinterface

// File: rtl/rom_access_ctrl.sv
// Two-port round-robin access controller for a 27128-style asynchronous EPROM.
// Optional one-entry last-read cache enabled by macro ROM_CTRL_HIT_EN.
module rom_access_ctrl #(
    parameter int ADDR_W      = 15,
    parameter int WAIT_CYCLES = 3,
    parameter int TURN_CYCLES = 1
) (
    input logic              clk,
    input logic              rst,
    rom_access_ctrl_if.slave bus
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("rom_access_ctrl: WAIT_CYCLES out of range 1..15");
    end
    if (TURN_CYCLES < 1 || TURN_CYCLES > 7) begin : g_bad_turn
        $error("rom_access_ctrl: TURN_CYCLES out of range 1..7");
    end

    localparam logic [3:0] WAIT_M1 = 4'(WAIT_CYCLES - 1);
    localparam logic [3:0] TURN_M1 = 4'(TURN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        READ,
        TURN
`ifdef ROM_CTRL_HIT_EN
        , HIT
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        rdata_d;
    logic              ack0_d, ack1_d, cs_d, oe_d;
    logic              pick;
    logic [ADDR_W-1:0] pick_addr;

`ifdef ROM_CTRL_HIT_EN
    logic [ADDR_W-1:0] hit_addr_q, hit_addr_d;
    logic [7:0]        hit_data_q, hit_data_d;
    logic              hit_valid_q, hit_valid_d;
`endif

    // last_grant always names the port being served, so it doubles as the grant.
    assign pick      = (bus.req0 && bus.req1) ? ~last_grant_q : bus.req1;
    assign pick_addr = pick ? bus.addr1 : bus.addr0;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        addr_d       = bus.rom_addr;
        rdata_d      = bus.rdata;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        cs_d         = 1'b1;
        oe_d         = 1'b1;
`ifdef ROM_CTRL_HIT_EN
        hit_addr_d   = hit_addr_q;
        hit_data_d   = hit_data_q;
        hit_valid_d  = hit_valid_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    last_grant_d = pick;
                    addr_d       = pick_addr;
`ifdef ROM_CTRL_HIT_EN
                    if (hit_valid_q && (pick_addr == hit_addr_q)) begin
                        state_d = HIT;
                    end else begin
                        state_d = SETUP;
                        cs_d    = 1'b0;
                    end
`else
                    state_d = SETUP;
                    cs_d    = 1'b0;
`endif
                end
            end
            SETUP: begin
                state_d = READ;
                cnt_d   = WAIT_M1;
                cs_d    = 1'b0;
                oe_d    = 1'b0;
            end
            READ: begin
                if (cnt_q == 4'd0) begin
                    state_d = TURN;
                    cnt_d   = TURN_M1;
                    rdata_d = bus.rom_data;
                    ack0_d  = ~last_grant_q;
                    ack1_d  = last_grant_q;
`ifdef ROM_CTRL_HIT_EN
                    hit_addr_d  = bus.rom_addr;
                    hit_data_d  = bus.rom_data;
                    hit_valid_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    cs_d  = 1'b0;
                    oe_d  = 1'b0;
                end
            end
            TURN: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`ifdef ROM_CTRL_HIT_EN
            HIT: begin
                state_d = TURN;
                cnt_d   = TURN_M1;
                rdata_d = hit_data_q;
                ack0_d  = ~last_grant_q;
                ack1_d  = last_grant_q;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Every output is a register loaded with the value for the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= 1'b1;
            bus.rom_csN  <= 1'b1;
            bus.rom_oeN  <= 1'b1;
            bus.rom_addr <= '0;
            bus.rdata    <= 8'h00;
            bus.ack0     <= 1'b0;
            bus.ack1     <= 1'b0;
            bus.busy     <= 1'b0;
`ifdef ROM_CTRL_HIT_EN
            hit_addr_q   <= '0;
            hit_data_q   <= 8'h00;
            hit_valid_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            bus.rom_csN  <= cs_d;
            bus.rom_oeN  <= oe_d;
            bus.rom_addr <= addr_d;
            bus.rdata    <= rdata_d;
            bus.ack0     <= ack0_d;
            bus.ack1     <= ack1_d;
            bus.busy     <= (state_d != IDLE);
`ifdef ROM_CTRL_HIT_EN
            hit_addr_q   <= hit_addr_d;
            hit_data_q   <= hit_data_d;
            hit_valid_q  <= hit_valid_d;
`endif
        end
    end

endmodule

// File: tb/tb_rom_access_ctrl.sv
// Bench for rom_access_ctrl: directed checks on a default instance, random
// back-to-back traffic on a TURN_CYCLES=2 instance against a timing model.
module tb_rom_access_ctrl;

    localparam int R_W = 3;
    localparam int R_T = 2;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    rom_access_ctrl_if #(.ADDR_W(15)) bus1 ();
    rom_access_ctrl_if #(.ADDR_W(15)) bus2 ();

    function automatic logic [7:0] rom_f(input logic [14:0] a);
        case (a)
            15'h1234: return 8'hA5;
            15'h0100: return 8'h3C;
            default:  return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h5A;
        endcase
    endfunction

    // EPROM drives its bus only while both strobes are low.
    assign bus1.rom_data = (!bus1.rom_csN && !bus1.rom_oeN) ? rom_f(bus1.rom_addr) : 8'h00;
    assign bus2.rom_data = (!bus2.rom_csN && !bus2.rom_oeN) ? rom_f(bus2.rom_addr) : 8'h00;

    rom_access_ctrl #(.ADDR_W(15), .WAIT_CYCLES(3), .TURN_CYCLES(1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    rom_access_ctrl #(.ADDR_W(15), .WAIT_CYCLES(R_W), .TURN_CYCLES(R_T)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int          cyc, prev, waited, got, port;
    int          next_idle, s_start, ack_cyc, exp_port;
    logic        lg, hv, full, hit, p, exp_cs_low, exp_oe_low;
    logic [14:0] ha, cur_addr, a;
    logic [7:0]  exp_data;

    initial begin
        rst = 1'b1;
        bus1.req0 = 1'b0; bus1.req1 = 1'b0; bus1.addr0 = '0; bus1.addr1 = '0;
        bus2.req0 = 1'b0; bus2.req1 = 1'b0; bus2.addr0 = '0; bus2.addr1 = '0;
        repeat (3) @(negedge clk);

        chk("rst_csN", bus1.rom_csN, 1);
        chk("rst_oeN", bus1.rom_oeN, 1);
        chk("rst_addr", bus1.rom_addr, 0);
        chk("rst_rdata", bus1.rdata, 0);
        chk("rst_ack0", bus1.ack0, 0);
        chk("rst_ack1", bus1.ack1, 0);
        chk("rst_busy", bus1.busy, 0);
        rst = 1'b0;

        // single read from port 0
        @(negedge clk);
        bus1.req0 = 1'b1; bus1.addr0 = 15'h1234;
        chk("single_cs_0", bus1.rom_csN, 1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("single_cs_%0d", k), bus1.rom_csN, (k <= 4) ? 0 : 1);
            chk($sformatf("single_oe_%0d", k), bus1.rom_oeN, (k >= 2 && k <= 4) ? 0 : 1);
            chk($sformatf("single_ack0_%0d", k), bus1.ack0, (k == 5) ? 1 : 0);
            chk($sformatf("single_ack1_%0d", k), bus1.ack1, 0);
            chk($sformatf("single_busy_%0d", k), bus1.busy, 1);
            if (k <= 4) chk($sformatf("single_addr_%0d", k), bus1.rom_addr, 32'h1234);
        end
        chk("single_rdata", bus1.rdata, 32'hA5);
        bus1.req0 = 1'b0;
        @(negedge clk);
        chk("single_ack_end", bus1.ack0, 0);
        chk("single_busy_end", bus1.busy, 0);
        chk("single_rdata_hold", bus1.rdata, 32'hA5);

        // contention: both held from reset release
        rst = 1'b1;
        bus1.req0 = 1'b1; bus1.addr0 = 15'h0200;
        bus1.req1 = 1'b1; bus1.addr1 = 15'h0300;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0; prev = 0;
        for (int k = 0; k < 4; k++) begin
            waited = 0; got = 0;
            while (got == 0 && waited < 20) begin
                @(negedge clk);
                cyc++; waited++;
                if (bus1.ack0 || bus1.ack1) got = 1;
            end
            chk($sformatf("cont_ack_seen_%0d", k), got, 1);
            if (got != 0) begin
                port = bus1.ack1 ? 1 : 0;
                chk($sformatf("cont_port_%0d", k), port, k % 2);
                chk($sformatf("cont_both_%0d", k), bus1.ack0 & bus1.ack1, 0);
                chk($sformatf("cont_rdata_%0d", k), bus1.rdata,
                    rom_f(port == 1 ? bus1.addr1 : bus1.addr0));
                if (k > 0) chk($sformatf("cont_gap_%0d", k), cyc - prev, 6);
                prev = cyc;
                if (port == 1) bus1.req1 = 1'b0; else bus1.req0 = 1'b0;
                @(negedge clk); cyc++;
                @(negedge clk); cyc++;
                if (port == 1) begin
                    bus1.req1 = 1'b1; bus1.addr1 = bus1.addr1 + 15'd1;
                end else begin
                    bus1.req0 = 1'b1; bus1.addr0 = bus1.addr0 + 15'd1;
                end
            end
        end
        bus1.req0 = 1'b0; bus1.req1 = 1'b0;
        repeat (10) @(negedge clk);

        // reset in the 2nd READ cycle with req1 held
        bus1.req1 = 1'b1; bus1.addr1 = 15'h2222;
        repeat (3) @(negedge clk);
        chk("rmid_oe_low", bus1.rom_oeN, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rmid_csN", bus1.rom_csN, 1);
        chk("rmid_oeN", bus1.rom_oeN, 1);
        chk("rmid_rdata", bus1.rdata, 0);
        chk("rmid_ack1", bus1.ack1, 0);
        chk("rmid_busy", bus1.busy, 0);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("rmid_ack1_%0d", k), bus1.ack1, (k == 5) ? 1 : 0);
            chk($sformatf("rmid_ack0_%0d", k), bus1.ack0, 0);
            if (k == 1) chk("rmid_addr", bus1.rom_addr, 32'h2222);
        end
        chk("rmid_rdata_end", bus1.rdata, rom_f(15'h2222));
        bus1.req1 = 1'b0;
        @(negedge clk);

`ifdef ROM_CTRL_HIT_EN
        // cache hit path
        bus1.req0 = 1'b1; bus1.addr0 = 15'h0100;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("hit_fill_ack_%0d", k), bus1.ack0, (k == 5) ? 1 : 0);
        end
        chk("hit_fill_rdata", bus1.rdata, 32'h3C);
        bus1.req0 = 1'b0;
        @(negedge clk);
        bus1.req1 = 1'b1; bus1.addr1 = 15'h0100;
        chk("hit_cs_0", bus1.rom_csN, 1);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            chk($sformatf("hit_cs_%0d", k), bus1.rom_csN, 1);
            chk($sformatf("hit_oe_%0d", k), bus1.rom_oeN, 1);
            chk($sformatf("hit_ack1_%0d", k), bus1.ack1, (k == 2) ? 1 : 0);
        end
        chk("hit_rdata", bus1.rdata, 32'h3C);
        bus1.req1 = 1'b0;
        @(negedge clk);
        bus1.req0 = 1'b1; bus1.addr0 = 15'h0101;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("miss_ack0_%0d", k), bus1.ack0, (k == 5) ? 1 : 0);
            chk($sformatf("miss_cs_%0d", k), bus1.rom_csN, (k <= 4) ? 0 : 1);
        end
        chk("miss_rdata", bus1.rdata, rom_f(15'h0101));
        bus1.req0 = 1'b0;
        @(negedge clk);
`endif

        // random back-to-back traffic against the timing model
        next_idle = 0; s_start = -100; ack_cyc = -100; exp_port = 0;
        lg = 1'b1; hv = 1'b0; ha = '0; full = 1'b0; cur_addr = '0; exp_data = 8'h00;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            exp_cs_low = full && (c >= s_start + 1) && (c <= s_start + 1 + R_W);
            exp_oe_low = full && (c >= s_start + 2) && (c <= s_start + 1 + R_W);
            chk("rnd_busy", bus2.busy, ((c > s_start) && (c < next_idle)) ? 1 : 0);
            chk("rnd_csN", bus2.rom_csN, exp_cs_low ? 0 : 1);
            chk("rnd_oeN", bus2.rom_oeN, exp_oe_low ? 0 : 1);
            chk("rnd_oe_implies_cs", !bus2.rom_oeN && bus2.rom_csN, 0);
            if (exp_cs_low) chk("rnd_addr_stable", bus2.rom_addr, cur_addr);
            chk("rnd_ack0", bus2.ack0, (c == ack_cyc && exp_port == 0) ? 1 : 0);
            chk("rnd_ack1", bus2.ack1, (c == ack_cyc && exp_port == 1) ? 1 : 0);
            if (c == ack_cyc) chk("rnd_rdata", bus2.rdata, exp_data);

            if (bus2.ack0) bus2.req0 = 1'b0;
            else if (!bus2.req0 && $urandom_range(0, 1) == 1) begin
                bus2.req0 = 1'b1; bus2.addr0 = 15'h0400 + 15'($urandom_range(0, 5));
            end
            if (bus2.ack1) bus2.req1 = 1'b0;
            else if (!bus2.req1 && $urandom_range(0, 1) == 1) begin
                bus2.req1 = 1'b1; bus2.addr1 = 15'h0400 + 15'($urandom_range(0, 5));
            end

            if (c >= next_idle && (bus2.req0 || bus2.req1)) begin
                p = (bus2.req0 && bus2.req1) ? !lg : bus2.req1;
                lg = p;
                a = p ? bus2.addr1 : bus2.addr0;
                exp_port = p ? 1 : 0;
                cur_addr = a;
                s_start = c;
                exp_data = rom_f(a);
                hit = 1'b0;
`ifdef ROM_CTRL_HIT_EN
                hit = hv && (a == ha);
`endif
                if (hit) begin
                    full = 1'b0;
                    ack_cyc = c + 2;
                    next_idle = c + 2 + R_T;
                end else begin
                    full = 1'b1;
                    ack_cyc = c + 2 + R_W;
                    next_idle = c + 2 + R_W + R_T;
                    hv = 1'b1;
                    ha = a;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rom_access_ctrl.md
# rom_access_ctrl

Synchronous access controller for the 27128-style asynchronous EPROM. It shares one EPROM between two requesters (port 0, port 1) with round-robin arbitration. It sequences the active-low chip-select and output-enable with programmable wait states and bus-turnaround gaps, and returns the read byte with a one-cycle acknowledge. It sits between the CPU/boot-loader fetch paths and the EPROM pins on the system board.

## Interface
Parameters:
- `ADDR_W`, 15, EPROM address width.
- `WAIT_CYCLES`, 3, number of cycles `rom_oeN` is held low before data is sampled; range 1..15.
- `TURN_CYCLES`, 1, number of idle cycles with `rom_csN`/`rom_oeN` high after each access; range 1..7.

Ports:
- `clk`  in  1  single clock. One clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset.
- `req0`  in  1  port 0 read request, level.
- `addr0`  in  ADDR_W  port 0 address; held stable while `req0` is high.
- `ack0`  out  1  port 0 acknowledge, one-cycle pulse.
- `req1`  in  1  port 1 read request.
- `addr1`  in  ADDR_W  port 1 address.
- `ack1`  out  1  port 1 acknowledge.
- `rdata`  out  8  read data; valid in the ack cycle and held until the next ack.
- `busy`  out  1  high whenever the controller is not in IDLE.
- `rom_csN`  out  1  EPROM chip select, active low.
- `rom_oeN`  out  1  EPROM output enable, active low.
- `rom_addr`  out  ADDR_W  EPROM address.
- `rom_data`  in  8  EPROM data bus.

## Operation
- All outputs are registered.
- State machine: IDLE → SETUP → READ → TURN → IDLE. The HIT state exists only with the macro defined.
- **IDLE**: `rom_csN=1`, `rom_oeN=1`.
  - If any request is pending, grant one port, latch its address into `rom_addr`, and go to SETUP.
- **Arbitration**: register `last_grant` (reset value 1).
  - A single requester is granted directly.
  - When both ports request, grant the port not equal to `last_grant`, then update `last_grant`.
- **SETUP**: 1 cycle. `rom_csN=0`, `rom_oeN=1`, address stable.
- **READ**: `WAIT_CYCLES` cycles. `rom_csN=0`, `rom_oeN=0`; a down-counter tracks the wait.
  - On the clock edge ending the last READ cycle: `rdata <= rom_data`, the granted `ackN <= 1`, go to TURN.
- **TURN**: `TURN_CYCLES` cycles. `rom_csN=1`, `rom_oeN=1`, then IDLE. The ack cycle is the first TURN cycle.
- **Handshake**:
  - The requester holds `reqN` and `addrN` until its ack.
  - The requester must drop `reqN` in the cycle after ack. If `reqN` is still high when IDLE samples it, it is treated as a new request.
  - Ack is never asserted for a port that was not granted.
  - `ack0` and `ack1` are never high in the same cycle.
- **Invariants**:
  - `rom_oeN=0` implies `rom_csN=0`.
  - `rom_addr` changes only in IDLE.
- **Reset**: takes effect even mid-access.
  - State returns to IDLE with `rom_csN=1`, `rom_oeN=1`, `rom_addr=0`, `rdata=0`, `ack0=ack1=0`, `busy=0`, `last_grant=1`, counters 0.
  - An interrupted request gets no ack. A requester still holding `req` is re-served after reset.
- Parameter values outside the stated ranges are illegal. The implementation checks them with an elaboration-time error.

## Timing
- A request first sampled high in IDLE at cycle N produces:
  - SETUP at cycle N+1.
  - READ at cycles N+2 .. N+1+WAIT_CYCLES.
  - ack and `rdata` at cycle N+2+WAIT_CYCLES. With defaults, that is N+5.
- Earliest next SETUP is N+3+WAIT_CYCLES+TURN_CYCLES. With defaults, that is N+7.
- Sustained throughput with defaults: one byte per 6 cycles.
- `busy` rises at N+1 and falls when the state returns to IDLE.

## Configuration
- Macro: `ROM_CTRL_HIT_EN`.
- **Defined**: adds a one-entry last-read cache consisting of `hit_addr`, `hit_data` and `hit_valid` (reset value 0).
  - Every ROM read loads the cache and sets `hit_valid`.
  - In IDLE, if the granted address equals `hit_addr` and `hit_valid=1`, go to HIT instead of SETUP.
  - HIT lasts 1 cycle with `rom_csN`/`rom_oeN` held high. It ends by driving `rdata <= hit_data` and the ack, then goes to TURN.
  - Hit latency: request at N gives ack at N+2.
  - Arbitration and `last_grant` update are unchanged.
- **Not defined**: HIT state and cache registers are absent; every request performs a full ROM access.

## Test plan
- **Single read**: WAIT_CYCLES=3, `req0` at N with `addr0=0x1234`, ROM model returns 0xA5.
  - Required: `rom_csN` low N+1..N+4, `rom_oeN` low N+2..N+4, `rom_addr=0x1234`.
  - Required: `ack0` pulse and `rdata=0xA5` at N+5, nothing on `ack1`.
- **Contention**: `req0` and `req1` both held high from reset release, each dropped after its own ack and reasserted one cycle later.
  - Required: grants alternate 0,1,0,1; acks spaced 6 cycles apart; `rdata` matches each port's address.
- **Turnaround and invariants**: random back-to-back requests with TURN_CYCLES=2.
  - Required: `rom_csN` and `rom_oeN` high for at least 2 cycles between accesses.
  - Required: `rom_oeN` never low while `rom_csN` is high; `rom_addr` stable whenever `rom_csN`=0.
- **Reset mid-READ**: assert `rst` at the 2nd READ cycle with `req1` held.
  - Required: next cycle `rom_csN=1`, `rom_oeN=1`, `rdata=0`, no ack.
  - Required: after release, full access to `addr1` and `ack1` 5 cycles after the first IDLE sample.
- **Hit path** (`ROM_CTRL_HIT_EN`): read 0x0100 (data 0x3C), then re-request 0x0100 on port 1.
  - Required: second ack 2 cycles after its IDLE sample, `rdata=0x3C`, `rom_csN` stays high throughout.
  - Required: a read of 0x0101 then takes the full-latency path.
